// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: receiver FSM states and error codes.
// Used by ps2_receiver and ps2_master.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_rx_state_t;

   localparam logic [1:0] ERR_PARITY  = 2'b01;
   localparam logic [1:0] ERR_STOP    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;
   localparam int         PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: synchroniser, debounce filter and
// a one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic fall
);

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   filt_q;
   logic [CW-1:0]          cnt_q;

   assign synced = sync_q[SYNC_STAGES-1];

   // async line into clk domain, idles high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      end
   end

   // follow the line only after FILT_LEN equal differing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b1;
         cnt_q  <= '0;
         fall   <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (synced != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
               filt_q <= synced;
               cnt_q  <= '0;
               fall   <= ~synced;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_receiver.sv
// Host-side PS/2 frame receiver: deserialises 11-bit device frames
// and presents good bytes on a tdata/tvalid/tready stream.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] tdata,
   output logic       tvalid,
   input  logic       tready,
   output logic       busy,
   output logic       err,
   output logic [1:0] err_type,
   output logic       overrun
);

   localparam int TW = $clog2(TIMEOUT_CYC);

   ps2_rx_state_t          state;
   logic [2:0]             bit_cnt;
   logic [PS2_DATA_BITS-1:0] shreg;
   logic                   par_q;
   logic [TW-1:0]          tocnt;
   logic [SYNC_STAGES-1:0] dsync_q;
   logic                   strobe;
   logic                   sbit;
   logic                   parity_ok;
   logic                   good;

   ps2_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_clk_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (ps2_clk),
      .fall  (strobe)
   );

   // data line is synchronised only; same depth keeps it aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dsync_q <= '1;
      end else begin
         dsync_q <= {dsync_q[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign sbit      = dsync_q[SYNC_STAGES-1];
   assign busy      = (state != IDLE);
   assign parity_ok = ^{shreg, par_q};

   // frame is good when the stop strobe closes a clean frame
   always_comb begin
      good = 1'b0;
      if (state == STOP && strobe && parity_ok && sbit) begin
         good = 1'b1;
      end
   end

   // frame FSM with mid-frame watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_q    <= 1'b0;
         tocnt    <= '0;
         err      <= 1'b0;
         err_type <= 2'b00;
      end else begin
         err <= 1'b0;
         if (state == IDLE) begin
            tocnt <= '0;
            if (strobe && !sbit) begin
               state   <= DATA;
               bit_cnt <= '0;
            end
         end else if (strobe) begin
            tocnt <= '0;
            unique case (state)
               DATA: begin
                  shreg   <= {sbit, shreg[PS2_DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par_q <= sbit;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!parity_ok) begin
                     err      <= 1'b1;
                     err_type <= ERR_PARITY;
                  end else if (!sbit) begin
                     err      <= 1'b1;
                     err_type <= ERR_STOP;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (tocnt == TW'(TIMEOUT_CYC - 1)) begin
            state    <= IDLE;
            tocnt    <= '0;
            bit_cnt  <= '0;
            err      <= 1'b1;
            err_type <= ERR_TIMEOUT;
         end else begin
            tocnt <= tocnt + 1'b1;
         end
      end
   end

   // single-entry output register; a full, stalled register drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdata   <= '0;
         tvalid  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (good) begin
            if (!tvalid || tready) begin
               tdata  <= shreg;
               tvalid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (tvalid && tready) begin
            tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: clean, corrupt, stalled,
// timed-out and reset-interrupted PS/2 frames.
module tb_ps2_receiver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready = 1'b1;
   logic       busy;
   logic       err;
   logic [1:0] err_type;
   logic       overrun;

   int nvec = 0;
   int nerr = 0;

   int         err_cnt = 0;
   int         ovr_cnt = 0;
   int         acc_cnt = 0;
   int         val_cyc = 0;
   int         busy_cyc = 0;
   logic [1:0] last_et = 2'b00;
   logic [7:0] acc_data = 8'h00;

   always #5 clk = ~clk;

   ps2_receiver #(
      .SYNC_STAGES (2),
      .FILT_LEN    (2),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .tdata    (tdata),
      .tvalid   (tvalid),
      .tready   (tready),
      .busy     (busy),
      .err      (err),
      .err_type (err_type),
      .overrun  (overrun)
   );

   // event monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (err) begin
         err_cnt = err_cnt + 1;
         last_et = err_type;
      end
      if (overrun) ovr_cnt = ovr_cnt + 1;
      if (tvalid) val_cyc = val_cyc + 1;
      if (busy) busy_cyc = busy_cyc + 1;
      if (tvalid && tready) begin
         acc_cnt  = acc_cnt + 1;
         acc_data = tdata;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec = nvec + 1;
      if (obs !== exp) begin
         nerr = nerr + 1;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      @(posedge clk);
      err_cnt  = 0;
      ovr_cnt  = 0;
      acc_cnt  = 0;
      val_cyc  = 0;
      busy_cyc = 0;
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one PS/2 bit: data set while clk high, 40 clk period
   task automatic send_bit(input logic b);
      ps2_data = b;
      wclk(10);
      ps2_clk = 1'b0;
      wclk(20);
      ps2_clk = 1'b1;
      wclk(10);
   endtask

   // first nbits of start, data LSB-first, parity, stop
   task automatic send_frame(input logic [7:0] d,
                             input logic p,
                             input logic s,
                             input int nbits);
      logic [10:0] f;
      f = {s, p, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         send_bit(f[i]);
      end
      ps2_data = 1'b1;
   endtask

   initial begin
      wclk(3);
      chk("rst_tdata", {24'd0, tdata}, 32'h00);
      chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_etype", {30'd0, err_type}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      rst_n = 1'b1;
      wclk(5);

      // 1: clean A5, consumer ready
      clr();
      send_frame(8'hA5, 1'b1, 1'b1, 11);
      wclk(10);
      chk("t1_acc", acc_cnt, 1);
      chk("t1_data", {24'd0, acc_data}, 32'hA5);
      chk("t1_vcyc", val_cyc, 1);
      chk("t1_err", err_cnt, 0);
      chk("t1_busy", {31'd0, busy}, 32'd0);

      // 2: FF with even parity
      clr();
      send_frame(8'hFF, 1'b0, 1'b1, 11);
      wclk(10);
      chk("t2_err", err_cnt, 1);
      chk("t2_etype", {30'd0, last_et}, 32'd1);
      chk("t2_vcyc", val_cyc, 0);
      chk("t2_busy", {31'd0, busy}, 32'd0);

      // 3: 00 with bad stop
      clr();
      send_frame(8'h00, 1'b1, 1'b0, 11);
      wclk(10);
      chk("t3_err", err_cnt, 1);
      chk("t3_etype", {30'd0, last_et}, 32'd2);
      chk("t3_vcyc", val_cyc, 0);

      // 4: stalled consumer, second byte overruns
      clr();
      tready = 1'b0;
      send_frame(8'h12, 1'b1, 1'b1, 11);
      wclk(5);
      chk("t4_v1", {31'd0, tvalid}, 32'd1);
      chk("t4_d1", {24'd0, tdata}, 32'h12);
      send_frame(8'h34, 1'b0, 1'b1, 11);
      wclk(5);
      chk("t4_v2", {31'd0, tvalid}, 32'd1);
      chk("t4_d2", {24'd0, tdata}, 32'h12);
      chk("t4_ovr", ovr_cnt, 1);
      chk("t4_err", err_cnt, 0);
      tready = 1'b1;
      wclk(3);
      chk("t4_acc", acc_cnt, 1);
      chk("t4_accd", {24'd0, acc_data}, 32'h12);
      chk("t4_vlow", {31'd0, tvalid}, 32'd0);

      // 5: clock halts after 4 data bits
      clr();
      send_frame(8'h0F, 1'b1, 1'b1, 5);
      wclk(30);
      chk("t5_busy", {31'd0, busy}, 32'd1);
      chk("t5_early", err_cnt, 0);
      wclk(20);
      chk("t5_err", err_cnt, 1);
      chk("t5_etype", {30'd0, last_et}, 32'd3);
      chk("t5_idle", {31'd0, busy}, 32'd0);
      wclk(50);
      clr();
      send_frame(8'h5A, 1'b1, 1'b1, 11);
      wclk(10);
      chk("t5_acc", acc_cnt, 1);
      chk("t5_data", {24'd0, acc_data}, 32'h5A);
      chk("t5_err2", err_cnt, 0);

      // 6: glitch ignored, reset mid-frame, then C3
      clr();
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wclk(1);
      ps2_clk  = 1'b1;
      wclk(15);
      ps2_data = 1'b1;
      chk("t6_glitch", busy_cyc, 0);
      send_frame(8'hC3, 1'b1, 1'b1, 5);
      chk("t6_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      wclk(2);
      chk("t6_tdata", {24'd0, tdata}, 32'h00);
      chk("t6_tvalid", {31'd0, tvalid}, 32'd0);
      chk("t6_rbusy", {31'd0, busy}, 32'd0);
      chk("t6_rerr", {31'd0, err}, 32'd0);
      chk("t6_retype", {30'd0, err_type}, 32'd0);
      chk("t6_rovr", {31'd0, overrun}, 32'd0);
      rst_n = 1'b1;
      wclk(10);
      clr();
      send_frame(8'hC3, 1'b1, 1'b1, 11);
      wclk(10);
      chk("t6_acc", acc_cnt, 1);
      chk("t6_data", {24'd0, acc_data}, 32'hC3);
      chk("t6_err", err_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
